// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: arbiter state encodings and defaults.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_OWN_L = 2'b01;
  localparam state_t ST_OWN_M = 2'b10;

  localparam int MAX_HOLD_DEFAULT = 8;

  // True for either ownership state.
  function automatic logic is_own(input state_t s);
    return (s == ST_OWN_L) || (s == ST_OWN_M);
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/grant and steering-data bundle between the two requesters and the arbiter.
interface mux_arbiter_if #(
  parameter int NBITS = 7
);

  logic             req_lsb;
  logic             req_msb;
  logic [NBITS-1:0] lsb;
  logic [NBITS-1:0] msb;
  logic             gnt_lsb;
  logic             gnt_msb;
  logic             dec;
  logic [NBITS-1:0] out;
  logic             out_valid;
  logic             preempt;

  modport master (
    output req_lsb, req_msb, lsb, msb,
    input  gnt_lsb, gnt_msb, dec, out, out_valid, preempt
  );

  modport slave (
    input  req_lsb, req_msb, lsb, msb,
    output gnt_lsb, gnt_msb, dec, out, out_valid, preempt
  );

endinterface

// File: rtl/hold_counter.sv
// Contended-hold counter: counts grant cycles while the other side waits.
module hold_counter #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; the owner is forced off at terminal count, so no wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter with bounded hold, steering one 2:1 data mux.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_IDLE  | nobody owns the mux; dec keeps last value
//   ST_OWN_L | LSB side granted, dec = 0
//   ST_OWN_M | MSB side granted, dec = 1
module mux_arbiter
  import pipe_ctrl_pkg::*;
#(
  parameter int nbits    = 7,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.slave  bus
);

  state_t state_q, state_d;
  logic   dec_q, dec_d;
  logic   last_msb_q, last_msb_d;
  logic   preempt_q, preempt_d;
  logic   cnt_clr, cnt_inc, cnt_term;
  logic [nbits-1:0] sel_data;

  hold_counter #(
    .CNT_W    (CNT_W),
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .term_o (cnt_term)
  );

  // Next-state, hold counter control, and select/priority bookkeeping.
  always_comb begin
    state_d    = state_q;
    dec_d      = dec_q;
    last_msb_d = last_msb_q;
    preempt_d  = 1'b0;
    cnt_clr    = 1'b1;
    cnt_inc    = 1'b0;

    case (state_q)
      ST_OWN_L: begin
        if (!bus.req_lsb) begin
          state_d = bus.req_msb ? ST_OWN_M : ST_IDLE;
        end else if (bus.req_msb) begin
          if (cnt_term) begin
            state_d   = ST_OWN_M;
            preempt_d = 1'b1;
          end else begin
            cnt_clr = 1'b0;
            cnt_inc = 1'b1;
          end
        end
      end
      ST_OWN_M: begin
        if (!bus.req_msb) begin
          state_d = bus.req_lsb ? ST_OWN_L : ST_IDLE;
        end else if (bus.req_lsb) begin
          if (cnt_term) begin
            state_d   = ST_OWN_L;
            preempt_d = 1'b1;
          end else begin
            cnt_clr = 1'b0;
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        // Also recovers the unused encoding 2'b11.
        if (bus.req_lsb && bus.req_msb) begin
          state_d = last_msb_q ? ST_OWN_L : ST_OWN_M;
        end else if (bus.req_lsb) begin
          state_d = ST_OWN_L;
        end else if (bus.req_msb) begin
          state_d = ST_OWN_M;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // A new owner moves the mux select and becomes the last-served side.
    if ((state_d != state_q) && is_own(state_d)) begin
      dec_d      = (state_d == ST_OWN_M);
      last_msb_d = (state_d == ST_OWN_M);
    end
  end

  // State, select and pulse registers; last_msb resets high so the first tie goes to LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dec_q      <= 1'b0;
      last_msb_q <= 1'b1;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_q      <= dec_d;
      last_msb_q <= last_msb_d;
      preempt_q  <= preempt_d;
    end
  end

  assign bus.gnt_lsb   = (state_q == ST_OWN_L);
  assign bus.gnt_msb   = (state_q == ST_OWN_M);
  assign bus.out_valid = bus.gnt_lsb | bus.gnt_msb;
  assign bus.dec       = dec_q;
  assign bus.preempt   = preempt_q;

  assign sel_data = dec_q ? bus.msb : bus.lsb;
  assign bus.out  = rst ? '0 : sel_data;

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 datapath mux between two requesters, an LSB-side source and an MSB-side source.
- Generates registered grants and the mux select `dec`.
- Enforces a bounded hold time, so one requester cannot starve the other.
- Sits in the pipeline control path, in front of the 7-bit select/steering mux.

Parameters:
- nbits, 7: data width steered through the block.
- MAX_HOLD, 8: maximum consecutive grant cycles while the other side is requesting. Legal range 2..255.
- CNT_W, 8: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_lsb  in  1  LSB-side requester wants the resource; held high while using it.
- req_msb  in  1  MSB-side requester; same rules.
- lsb  in  nbits  LSB-side data.
- msb  in  nbits  MSB-side data.
- gnt_lsb  out  1  registered grant to the LSB side.
- gnt_msb  out  1  registered grant to the MSB side.
- dec  out  1  registered mux select: 1 = msb, 0 = lsb.
- out  out  nbits  selected data, combinational from `dec`.
- out_valid  out  1  gnt_lsb | gnt_msb.
- preempt  out  1  one-cycle pulse when a grant is forcibly revoked by hold timeout.

Behaviour:
- One clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values:
  - state = IDLE, gnt_lsb = 0, gnt_msb = 0, dec = 0, preempt = 0.
  - hold_cnt = 0, last_msb = 1, so the first tie goes to LSB.
  - `out` = 0 while rst is high; afterwards `out` = dec ? msb : lsb.
- States: IDLE, OWN_L, OWN_M. Grants are decoded from the state register: gnt_lsb = (state == OWN_L), gnt_msb = (state == OWN_M).
- Grants are never both high.
- Latency: a request sampled at edge N yields its grant visible after edge N, i.e. one cycle.
- IDLE transitions:
  - neither request → stay in IDLE; dec holds its previous value.
  - only req_lsb → OWN_L.
  - only req_msb → OWN_M.
  - both → the side with last_msb == 0 wins, i.e. MSB wins if LSB was served last.
  - On entering any OWN state: hold_cnt = 0, dec updated in the same edge, last_msb updated.
- OWN_X transitions, with Y the other side:
  - req_X low and req_Y high → OWN_Y directly, with no idle bubble.
  - req_X low and req_Y low → IDLE.
  - req_X high, req_Y high, hold_cnt == MAX_HOLD-1 → OWN_Y; preempt = 1 for one cycle.
  - otherwise stay in OWN_X. hold_cnt increments only while req_Y is high; it is cleared while req_Y is low.
- Counter never wraps; it is bounded by the preemption rule.
- Simultaneous release of X and request by Y is treated as the direct handover above.
- Reset asserted mid-grant drops both grants immediately (asynchronous). There is no completion handshake. The first post-reset tie goes to LSB.
- A requester whose req drops for a single cycle loses ownership. Re-requesting re-arbitrates.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - state encodings ST_IDLE = 2'b00, ST_OWN_L = 2'b01, ST_OWN_M = 2'b10.
  - default MAX_HOLD constant.
- One natural sub-module, `hold_counter`: a CNT_W-bit counter with clr, inc and terminal flag (cnt == MAX_HOLD-1).
- The output steering is a plain 2:1 select inside this block.

Test Plan:
- Reset then idle: rst high 3 cycles with both reqs toggling → grants 0, dec = 0, out = 0; after release with no requests, grants stay 0.
- Single requester: req_msb = 1 at cycle 5, msb = 7'h55 → gnt_msb = 1 and dec = 1 from cycle 6, out = 7'h55 while held; req_msb low at cycle 10 → IDLE at cycle 11, dec stays 1.
- Tie after reset: both reqs high at cycle 1 → gnt_lsb at cycle 2. LSB drops at cycle 4 with MSB still high → gnt_msb at cycle 5, with no cycle where both grants are 0.
- Preemption (MAX_HOLD = 8): LSB owns, req_msb rises and both stay high → after 8 contended grant cycles gnt_lsb falls, gnt_msb rises the same edge, preempt pulses exactly 1 cycle. Repeated contention alternates ownership every 8 cycles.
- Async reset mid-grant: assert rst between clock edges while gnt_msb = 1 → gnt_msb, dec and out go to 0 before the next edge. Deassert with both reqs high → LSB granted first.
- Random-request soak of 10k cycles: check mutual exclusion, dec == gnt_msb whenever out_valid, and no requester waiting more than MAX_HOLD + 1 cycles.
